// File: rtl/muldiv_sequencer.sv
// Iterative M-extension unit: shift-add MUL and restoring DIV/REM, one bit per cycle,
// with valid/ready request and response ports and a busy stall output.
module muldiv_sequencer #(
  parameter int DATA_BITS = 32,
  parameter int CTRL_BITS = 4,
  parameter int CTRL_MUL  = 3,
  parameter int CTRL_DIV  = 4,
  parameter int CTRL_REM  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CTRL_BITS-1:0] ctrl,
  input  logic [DATA_BITS-1:0] in1,
  input  logic [DATA_BITS-1:0] in2,
  input  logic                 flush,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_BITS-1:0] result,
  output logic                 busy
);

  localparam int CNT_BITS = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [DATA_BITS-1:0] a_q, a_d;     // multiplicand / divisor magnitude
  logic [DATA_BITS-1:0] b_q, b_d;     // multiplier / dividend shifting into quotient
  logic [DATA_BITS-1:0] acc_q, acc_d; // product accumulator / partial remainder
  logic                 is_mul_q, is_mul_d, is_rem_q, is_rem_d;
  logic                 sign1_q, sign1_d, sign2_q, sign2_d;
  logic [DATA_BITS-1:0] result_q, result_d;
  logic                 resp_valid_q, resp_valid_d, busy_q, busy_d;

  logic [DATA_BITS:0]   rem_shift;
  logic                 rem_ge;
  logic [DATA_BITS-1:0] rem_next, quo_next, mul_next;
  logic                 op_mul, op_div, op_rem, div_ovf;

  function automatic logic [DATA_BITS-1:0] mag(input logic [DATA_BITS-1:0] v);
    return v[DATA_BITS-1] ? -v : v;
  endfunction

  always_comb begin
    op_mul  = (ctrl == CTRL_BITS'(CTRL_MUL));
    op_div  = (ctrl == CTRL_BITS'(CTRL_DIV));
    op_rem  = (ctrl == CTRL_BITS'(CTRL_REM));
    div_ovf = (in1 == {1'b1, {(DATA_BITS-1){1'b0}}}) && (in2 == '1);

    // Remainder stays below the divisor, so DATA_BITS bits of it are stored
    // and the extra bit only exists in the shifted trial value.
    rem_shift = {acc_q, b_q[DATA_BITS-1]};
    rem_ge    = (rem_shift >= {1'b0, a_q});
    rem_next  = rem_ge ? DATA_BITS'(rem_shift - {1'b0, a_q}) : rem_shift[DATA_BITS-1:0];
    quo_next  = (b_q << 1) | DATA_BITS'(rem_ge);
    mul_next  = acc_q + (b_q[0] ? a_q : '0);

    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    is_mul_d = is_mul_q;
    is_rem_d = is_rem_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          is_mul_d = op_mul;
          is_rem_d = op_rem;
          sign1_d  = in1[DATA_BITS-1];
          sign2_d  = in2[DATA_BITS-1];
          cnt_d    = '0;
          acc_d    = '0;
          if (op_mul) begin
            a_d     = in1;
            b_d     = in2;
            state_d = CALC;
          end else if (op_div || op_rem) begin
            if (in2 == '0) begin
              result_d = op_rem ? in1 : '1;
              state_d  = DONE;
            end else if (div_ovf) begin
              result_d = op_rem ? '0 : in1;
              state_d  = DONE;
            end else begin
              a_d     = mag(in2);
              b_d     = mag(in1);
              state_d = CALC;
            end
          end else begin
            result_d = '0;
            state_d  = DONE;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_mul_q) begin
            acc_d = mul_next;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
          end else begin
            acc_d = rem_next;
            b_d   = quo_next;
          end
          if (cnt_q == CNT_BITS'(DATA_BITS - 1)) begin
            state_d = DONE;
            if (is_mul_q)
              result_d = mul_next;
            else if (is_rem_q)
              result_d = sign1_q ? -rem_next : rem_next;
            else
              result_d = (sign1_q ^ sign2_q) ? -quo_next : quo_next;
          end
        end
      end
      DONE: begin
        if (flush || resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    resp_valid_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      is_mul_q     <= 1'b0;
      is_rem_q     <= 1'b0;
      sign1_q      <= 1'b0;
      sign2_q      <= 1'b0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      is_mul_q     <= is_mul_d;
      is_rem_q     <= is_rem_d;
      sign1_q      <= sign1_d;
      sign2_q      <= sign2_d;
      result_q     <= result_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = !busy_q && !flush;
  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;
  assign result     = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: vector table through a result/latency scoreboard,
// plus hand-written hold, flush and asynchronous-reset sequences.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, flush, resp_valid, resp_ready, busy;
  logic [3:0]  ctrl;
  logic [31:0] in1, in2, result;

  int nvec = 0;
  int nfail = 0;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_res[$];
  int          sb_lat[$];

  muldiv_sequencer #(.DATA_BITS(32), .CTRL_BITS(4), .CTRL_MUL(3), .CTRL_DIV(4), .CTRL_REM(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .ctrl(ctrl),
    .in1(in1), .in2(in2), .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    if (c == 4'd3) return a * b;
    if (c != 4'd4 && c != 4'd5) return 32'd0;
    if (b == 32'd0) return (c == 4'd4) ? 32'hFFFF_FFFF : a;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (c == 4'd4) ? 32'h8000_0000 : 32'd0;
    return (c == 4'd4) ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    if (c == 4'd3) return 33;
    if (c != 4'd4 && c != 4'd5) return 1;
    if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Latency counts edges from the accepting edge (inclusive) to the edge that raises resp_valid.
  task automatic wait_resp(input string name, input int start_edges);
    int          edges;
    logic [31:0] e;
    int          l;
    edges = start_edges;
    while (!resp_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    if (sb_res.size() == 0) begin
      check({name, " scoreboard"}, 32'd1, 32'd0);
    end else begin
      e = sb_res.pop_front();
      l = sb_lat.pop_front();
      check({name, " latency"}, 32'(edges), 32'(l));
      check({name, " result"}, result, e);
    end
  endtask

  task automatic do_req(input string name, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    sb_res.push_back(exp);
    sb_lat.push_back(lat);
    @(negedge clk);
    ctrl = c; in1 = a; in2 = b; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(name, 1);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({name, " busy after handshake"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int hits;
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    ctrl = '0; in1 = '0; in2 = '0;
    #12;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{4'd3, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{4'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33});
    vecs.push_back('{4'd5, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33});
    vecs.push_back('{4'd4, 32'd100,        32'd7,          32'd14,        33});
    vecs.push_back('{4'd5, 32'd100,        32'd7,          32'd2,         33});
    vecs.push_back('{4'd4, 32'd5,          32'd0,          32'hFFFF_FFFF, 1});
    vecs.push_back('{4'd5, 32'd5,          32'd0,          32'd5,         1});
    vecs.push_back('{4'd2, 32'd5,          32'd3,          32'd0,         1});
    vecs.push_back('{4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{4'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{4'd5, 32'd100,        32'hFFFF_FFF9, 32'd2,         33});
    vecs.push_back('{4'd4, 32'd3,          32'd7,          32'd0,         33});
    for (int i = 0; i < 8; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      c = 4'(3 + $urandom_range(0, 2));
      a = $urandom;
      b = (i == 7) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      vecs.push_back('{c, a, b, model(c, a, b), model_lat(c, a, b)});
    end
    foreach (vecs[i])
      do_req($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Response held in DONE, then a back-to-back request behind the handshake.
    sb_res.push_back(32'd42); sb_lat.push_back(33);
    @(negedge clk);
    ctrl = 4'd3; in1 = 32'd6; in2 = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp("hold", 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold result", result, 32'd42);
      check("hold req_ready", 32'(req_ready), 32'd0);
      check("hold busy", 32'(busy), 32'd1);
    end
    sb_res.push_back(32'd14); sb_lat.push_back(33);
    resp_ready = 1'b1; req_valid = 1'b1; ctrl = 4'd4; in1 = 32'd100; in2 = 32'd7;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("b2b idle resp_valid", 32'(resp_valid), 32'd0);
    check("b2b idle busy", 32'(busy), 32'd0);
    check("b2b idle req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b accepted busy", 32'(busy), 32'd1);
    wait_resp("b2b", 1);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;

    // Flush at iteration 10 of a divide.
    @(negedge clk);
    ctrl = 4'd4; in1 = 32'd100; in2 = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush resp_valid", 32'(resp_valid), 32'd0);
    check("flush busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("flush req_ready", 32'(req_ready), 32'd1);
    hits = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) hits++;
    end
    check("flush no response", 32'(hits), 32'd0);
    do_req("post-flush mul", 4'd3, 32'd3, 32'd4, 32'd12, 33);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; ctrl = 4'd3; in1 = 32'd2; in2 = 32'd2;
    #1;
    check("idle flush req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("idle flush no accept", 32'(busy), 32'd0);
    flush = 1'b0; req_valid = 1'b0;

    // Asynchronous reset between edges while calculating.
    @(negedge clk);
    ctrl = 4'd3; in1 = 32'd9; in2 = 32'd9; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst resp_valid", 32'(resp_valid), 32'd0);
    check("async rst result", result, 32'd0);
    check("async rst req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_req("post-reset rem", 4'd5, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
